// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO drain stage.
package fifo_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry output buffer (head + skid) with push/pop/flush; head is always the oldest byte.
module stream_skid2
  import fifo_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    occ,
  output logic [DW-1:0] head,
  output logic          valid
);

  localparam logic [1:0] ST_EMPTY = EMPTY;
  localparam logic [1:0] ST_ONE   = ONE;
  localparam logic [1:0] ST_TWO   = TWO;

  logic [1:0]    state_q, state_d;
  logic [1:0]    occ_d;
  logic [DW-1:0] head_d;
  logic [DW-1:0] skid_q, skid_d;

  // State and data registers; occ/valid are registered alongside the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      occ     <= 2'd0;
      valid   <= 1'b0;
      head    <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      occ     <= occ_d;
      valid   <= (state_d != ST_EMPTY);
      head    <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state logic; a push in TWO cannot happen because the issue rule prevents it.
  always_comb begin
    state_d = state_q;
    head_d  = head;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            head_d  = push_data;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            state_d = ST_TWO;
            skid_d  = push_data;
          end else if (pop && !push) begin
            state_d = ST_EMPTY;
          end else if (push && pop) begin
            head_d = push_data;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d = ST_ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    occ_d = 2'd0;
    case (state_d)
      ST_ONE:  occ_d = 2'd1;
      ST_TWO:  occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

endmodule

// File: rtl/fifo_stream_drain.sv
// Pops the byte FIFO and presents bytes on a valid/ready stream, hiding the 1-cycle read latency.
module fifo_stream_drain
  import fifo_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    fifo_dout,
  input  logic             fifo_empty,
  input  logic             fifo_wr_seen,
  output logic             fifo_rd,
  input  logic             flush,
  output logic [DW-1:0]    m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] byte_cnt
);

  logic       inflight_q;
  logic       pop;
  logic       push;
  logic       acc;
  logic [1:0] occ;
  logic [2:0] outstanding;

  assign pop         = m_valid && m_ready && !flush;
  assign outstanding = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign fifo_rd     = !rst && !flush && !fifo_empty && (outstanding < 3'd2);
  // A read in a cycle where the FIFO accepts a write is ignored by the FIFO.
  assign acc         = fifo_rd && !fifo_empty && !fifo_wr_seen;
  assign push        = inflight_q && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      inflight_q <= acc;
      byte_cnt   <= byte_cnt + CNT_W'(pop);
    end
  end

  stream_skid2 #(
    .DW(DW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (fifo_dout),
    .pop       (pop),
    .occ       (occ),
    .head      (m_data),
    .valid     (m_valid)
  );

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Drives fifo_stream_drain from a queue-based FIFO model and scoreboards the delivered byte stream.
module tb_fifo_stream_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_wr_seen;
  logic        fifo_rd;
  logic        flush;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] byte_cnt;

  always #5 clk = ~clk;

  fifo_stream_drain #(.DW(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_wr_seen (fifo_wr_seen),
    .fifo_rd      (fifo_rd),
    .flush        (flush),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .byte_cnt     (byte_cnt)
  );

  logic [7:0]  fq[$];     // contents of the upstream FIFO
  logic [7:0]  exp_q[$];  // bytes read from the FIFO and not yet delivered or discarded
  logic [15:0] exp_cnt;
  int          n_vec = 0;
  int          n_err = 0;
  logic        obs_rd, obs_valid, obs_deliv;
  logic [7:0]  obs_data;
  logic        prev_stall;
  logic [7:0]  prev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, sample mid-cycle, advance the models after the edge.
  task automatic cycle(input logic wr_en, input logic [7:0] wr_byte, input logic rdy,
                       input logic fl, input logic r);
    logic       wr_acc, acc, exp_rd;
    int         pend;
    logic [7:0] b;
    rst          = r;
    flush        = fl;
    m_ready      = rdy;
    wr_acc       = wr_en && (fq.size() < 16);
    fifo_wr_seen = wr_acc;
    fifo_empty   = (fq.size() == 0);
    #2;
    obs_rd    = fifo_rd;
    obs_valid = m_valid;
    obs_data  = m_data;
    obs_deliv = m_valid && rdy && !fl && !r;
    pend      = exp_q.size() - (obs_deliv ? 1 : 0);
    exp_rd    = !r && !fl && !fifo_empty && (pend < 2);
    check("fifo_rd", 32'(obs_rd), 32'(exp_rd));
    if (prev_stall) begin
      check("hold_valid", 32'(obs_valid), 32'd1);
      check("hold_data", 32'(obs_data), 32'(prev_data));
    end
    if (obs_deliv) begin
      check("deliver_has_byte", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("m_data", 32'(obs_data), 32'(exp_q.pop_front()));
    end
    acc        = obs_rd && !fifo_empty && !wr_acc;
    prev_stall = m_valid && !rdy && !fl && !r;
    prev_data  = obs_data;
    @(posedge clk);
    #1;
    if (r || fl) exp_q.delete();
    if (acc && fq.size() > 0) begin
      b = fq.pop_front();
      fifo_dout = b;
      if (!r && !fl) exp_q.push_back(b);
    end
    if (wr_acc) fq.push_back(wr_byte);
    if (r) exp_cnt = 16'd0;
    else if (obs_deliv) exp_cnt = exp_cnt + 16'd1;
    check("byte_cnt", 32'(byte_cnt), 32'(exp_cnt));
    check("outstanding_le2", 32'(exp_q.size() <= 2), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((fq.size() > 0 || exp_q.size() > 0) && n < 200) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n++;
    end
    check({tag, "_drained"}, 32'(n < 200), 32'd1);
  endtask

  initial begin
    logic [15:0] wrap_exp [3];
    int          nrd, guard, k;
    logic        rv [5];
    logic        vv [5];
    logic [7:0]  dv [5];
    wrap_exp = '{16'hFFFF, 16'h0000, 16'h0001};
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; fifo_wr_seen = 1'b0;
    fifo_empty = 1'b1; fifo_dout = 8'h00; exp_cnt = 16'd0; prev_stall = 1'b0; prev_data = 8'h00;

    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rst_valid", 32'(obs_valid), 32'd0);
    check("rst_data", 32'(obs_data), 32'd0);
    check("rst_cnt", 32'(byte_cnt), 32'd0);
    check("rst_rd", 32'(obs_rd), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Latency and back-to-back delivery.
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      rv[i] = obs_rd; vv[i] = obs_valid; dv[i] = obs_data;
    end
    check("t1_rd_n0", 32'(rv[0]), 32'd1);
    check("t1_rd_n1", 32'(rv[1]), 32'd1);
    check("t1_rd_n2", 32'(rv[2]), 32'd1);
    check("t1_valid_n1", 32'(vv[1]), 32'd0);
    check("t1_data_n2", 32'(vv[2] ? dv[2] : 8'hXX), 32'h11);
    check("t1_data_n3", 32'(vv[3] ? dv[3] : 8'hXX), 32'h22);
    check("t1_data_n4", 32'(vv[4] ? dv[4] : 8'hXX), 32'h33);
    check("t1_cnt", 32'(byte_cnt), 32'd3);
    drain("t1");

    // Backpressure: only two reads outstanding, head held.
    for (int i = 0; i < 5; i++) fq.push_back(8'(8'hA0 + i));
    nrd = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (obs_rd) nrd++;
    end
    check("t2_reads", 32'(nrd), 32'd2);
    check("t2_valid", 32'(obs_valid), 32'd1);
    check("t2_head", 32'(obs_data), 32'hA0);
    check("t2_rd_idle", 32'(obs_rd), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("t2_stream_valid", 32'(obs_valid), 32'd1);
      check("t2_stream_data", 32'(obs_data), 32'(8'hA0 + i));
    end
    drain("t2");

    // Read colliding with a FIFO write is dropped and re-issued.
    fq.push_back(8'h5C);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    check("t3_rd_collide", 32'(obs_rd), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("t3_rd_reissue", 32'(obs_rd), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("t3_no_capture", 32'(obs_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("t3_first", 32'(obs_valid ? obs_data : 8'hXX), 32'h5C);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("t3_second", 32'(obs_valid ? obs_data : 8'hXX), 32'h77);
    drain("t3");

    // Flush with one byte buffered and one read in flight.
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'hEE); fq.push_back(8'h03);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t4_two_head", 32'(obs_valid ? obs_data : 8'hXX), 32'h01);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("t4_rd_inflight", 32'(obs_rd), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t4_rd_flush", 32'(obs_rd), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("t4_valid_after", 32'(obs_valid), 32'd0);
    check("t4_cnt", 32'(byte_cnt), 32'd11);
    guard = 0;
    while (!obs_valid && guard < 10) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    check("t4_first_after_flush", 32'(obs_data), 32'h03);
    drain("t4");

    // Randomised traffic, flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 399) == 0));
    end
    drain("rand");

    // Reset mid-stream with the buffer full and the consumer stalled.
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'h60 + i));
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t6_two", 32'(obs_valid ? obs_data : 8'hXX), 32'h60);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t6_rd_rst", 32'(obs_rd), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t6_valid", 32'(obs_valid), 32'd0);
    check("t6_data", 32'(obs_data), 32'd0);
    check("t6_cnt", 32'(byte_cnt), 32'd0);
    check("t6_rd_rst2", 32'(obs_rd), 32'd0);
    drain("t6");

    // Counter wrap.
    guard = 0;
    while (exp_cnt != 16'hFFFE && guard < 70000) begin
      if (fq.size() < 4) fq.push_back(8'($urandom));
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    check("t5_reach_fffe", 32'(exp_cnt), 32'hFFFE);
    k = 0;
    guard = 0;
    while (k < 3 && guard < 50) begin
      if (fq.size() < 4) fq.push_back(8'($urandom));
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      if (obs_deliv) begin
        check("t5_wrap", 32'(byte_cnt), 32'(wrap_exp[k]));
        k++;
      end
      guard++;
    end
    check("t5_wrap_done", 32'(k), 32'd3);
    drain("t5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_stream_drain.md
Name: fifo_stream_drain

Overview:
- Downstream stage of the 16x8 byte FIFO. Pops bytes from the FIFO read port and presents them on a valid/ready byte stream to the next consumer.
- Hides the FIFO's 1-cycle registered read latency with a 2-entry output buffer, so sustained throughput is 1 byte/clk when the FIFO is non-empty and the consumer is ready.
- Counts delivered bytes.

Parameters:
- DW, 8, data width; must match the FIFO data width.
- CNT_W, 16, width of the delivered-byte counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- fifo_dout  in  DW  FIFO registered read data; valid the cycle after an accepted read.
- fifo_empty  in  1  FIFO empty flag, combinational from FIFO count.
- fifo_wr_seen  in  1  copy of the FIFO write strobe; the FIFO ignores a read in any cycle where a write is accepted.
- fifo_rd  out  1  read strobe to FIFO; combinational.
- flush  in  1  synchronous; discards buffered and in-flight bytes.
- m_data  out  DW  stream data; equals buffer head.
- m_valid  out  1  stream valid.
- m_ready  in  1  consumer ready.
- byte_cnt  out  CNT_W  bytes delivered (m_valid && m_ready), wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at posedge): buffer state EMPTY, inflight=0, m_valid=0, m_data=0, byte_cnt=0. fifo_rd=0 while rst=1. Reset has priority over flush and all traffic, including mid-transfer.
- Buffer FSM: EMPTY (0 entries), ONE (1 entry), TWO (2 entries, head + skid). m_valid=1 in ONE/TWO.
- pop = m_valid && m_ready.
- Read acceptance: acc = fifo_rd && !fifo_empty && !fifo_wr_seen. The inflight register is set to acc each cycle. Only an accepted read produces data.
- Issue rule: fifo_rd = !rst && !flush && !fifo_empty && (occ + inflight - pop) < 2, where occ = 0/1/2. Never assert fifo_rd while fifo_empty=1.
- Capture: when inflight=1, fifo_dout is written into the buffer this cycle (push).
- Ordering is FIFO order; the head is always the oldest byte.
- Transitions:
  - EMPTY: push -> ONE.
  - ONE: push && !pop -> TWO; pop && !push -> EMPTY; push && pop -> ONE with the new head.
  - TWO: pop -> ONE, with the skid entry promoted to head (push cannot occur in TWO because the issue rule prevents it).
- Latency: FIFO non-empty at cycle N with the buffer empty -> fifo_rd at N, m_valid at N+2.
- Backpressure: m_data and m_valid are held stable while m_valid && !m_ready. No more than 2 bytes are outstanding (buffer + inflight ≤ 2).
- Simultaneous FIFO write + our read: the read is dropped (acc=0), no data is captured, and the read is re-issued the next cycle if the issue rule still holds.
- Flush: next state EMPTY, inflight=0. Any byte arriving from a read accepted in the flush cycle or the prior cycle is discarded. byte_cnt is unchanged. fifo_rd=0 during flush.
- byte_cnt increments by 1 per pop and wraps from 2^CNT_W-1 to 0.
- Any FSM encoding outside EMPTY/ONE/TWO recovers to EMPTY.

Decomposition:
- Package fifo_pkg: DW default, buf_state_e enum {EMPTY, ONE, TWO}.
- Sub-module stream_skid2: 2-entry buffer with push/pop/flush, exposing occ, head data and valid.
- Top level holds the issue/acceptance logic, the inflight register and byte_cnt.

Test Plan:
- Reset, then push 0x11,0x22,0x33 into FIFO with m_ready=1 -> fifo_rd at N, N+1, N+2; m_data 0x11,0x22,0x33 on consecutive cycles from N+2; byte_cnt=3.
- FIFO holds 0xA0..0xA4, m_ready=0 -> exactly 2 accepted reads; m_valid=1 with m_data=0xA0 held; fifo_rd=0 afterwards. Raise m_ready -> 0xA0..0xA4 delivered in order at 1/clk.
- fifo_wr_seen=1 in the same cycle as fifo_rd with FIFO holding 0x5C -> no capture the next cycle; read re-issued; 0x5C delivered exactly once.
- Buffer in TWO (0x01,0x02) with a read in flight; assert flush for one cycle -> m_valid=0 the next cycle, in-flight byte dropped; the next FIFO byte 0x03 is delivered first; byte_cnt unchanged.
- Preload byte_cnt to 0xFFFE via 2^16-2 deliveries (or force), then deliver 3 bytes -> byte_cnt goes 0xFFFF, 0x0000, 0x0001.
- Assert rst mid-stream with buffer in TWO and m_ready=0 -> next cycle m_valid=0, m_data=0, byte_cnt=0, fifo_rd=0 while rst is high.
